// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers; mthi/mtlo write in one edge.
// Latency MULT_CYCLES/DIV_CYCLES with busy held high; starts while busy are dropped, the pipeline stalls on busy.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic [3:0]  MDUop,
  input  logic        start,
  input  logic        clear,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] out
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   res_hi, res_lo, res_hi_n, res_lo_n;
  logic          res_wr, res_wr_n;
  logic [31:0]   hi_n, lo_n;

  // Signed division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
  logic        sgn_div, a_neg, b_neg, sgn_mul;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
  logic [63:0] prod;

  always_comb begin
    sgn_div = (MDUop == 4'd3);
    sgn_mul = (MDUop == 4'd1);
    a_neg   = sgn_div & D1[31];
    b_neg   = sgn_div & D2[31];
    a_mag   = a_neg ? (~D1 + 32'd1) : D1;
    b_mag   = b_neg ? (~D2 + 32'd1) : D2;
    q_mag   = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
    r_mag   = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
    quo     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem     = a_neg ? (~r_mag + 32'd1) : r_mag;
    prod    = {{32{sgn_mul & D1[31]}}, D1} * {{32{sgn_mul & D2[31]}}, D2};
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    res_hi_n = res_hi;
    res_lo_n = res_lo;
    res_wr_n = res_wr;
    hi_n     = HI;
    lo_n     = LO;
    if (clear) begin
      state_n  = IDLE;
      cnt_n    = '0;
      res_hi_n = '0;
      res_lo_n = '0;
      res_wr_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (MDUop)
              4'd1, 4'd2: begin
                res_hi_n = prod[63:32];
                res_lo_n = prod[31:0];
                res_wr_n = 1'b1;
                cnt_n    = CW'(MULT_CYCLES);
                state_n  = BUSY;
              end
              4'd3, 4'd4: begin
                res_hi_n = rem;
                res_lo_n = quo;
                // A zero divisor still occupies the unit but leaves HI/LO alone.
                res_wr_n = (D2 != 32'd0);
                cnt_n    = CW'(DIV_CYCLES);
                state_n  = BUSY;
              end
              4'd5:    hi_n = D1;
              4'd6:    lo_n = D1;
              default: ;
            endcase
          end
        end
        BUSY: begin
          cnt_n = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state_n = IDLE;
            if (res_wr) begin
              hi_n = res_hi;
              lo_n = res_lo;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_wr <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      res_hi <= res_hi_n;
      res_lo <= res_lo_n;
      res_wr <= res_wr_n;
      HI     <= hi_n;
      LO     <= lo_n;
    end
  end

  assign busy = (state == BUSY);

  always_comb begin
    case (MDUop)
      4'd7:    out = HI;
      4'd8:    out = LO;
      default: out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus pushes expected HI/LO/busy-length and reads,
// a negedge monitor pops and compares on busy completion or read cycles.
module tb_mdu_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk, reset_n, start, clear, busy;
  logic [31:0] D1, D2, HI, LO, out;
  logic [3:0]  MDUop;
  logic        rd_chk;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .D1(D1), .D2(D2), .MDUop(MDUop),
    .start(start), .clear(clear), .busy(busy), .HI(HI), .LO(LO), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] m_hi, m_lo;
  int          checks = 0;
  int          errors = 0;
  int          run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      run = 0;
    end else begin
      if (busy) begin
        run++;
      end else if (run > 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 32'(run), 32'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("busy_len", 32'(run), 32'(e.len));
          chk("HI", HI, e.hi);
          chk("LO", LO, e.lo);
        end
        run = 0;
      end
      if (rd_chk) begin
        if (rd_q.size() == 0) chk("read_queue_empty", out, 32'hDEAD_BEEF);
        else chk("out", out, rd_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] sel);
    MDUop  = sel;
    start  = 1'b0;
    rd_chk = 1'b1;
    rd_q.push_back(sel == 4'd7 ? m_hi : (sel == 4'd8 ? m_lo : 32'd0));
    tick();
    rd_chk = 1'b0;
    MDUop  = 4'd0;
  endtask

  // Reference arithmetic on wide integers, independent of the DUT's datapath.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    longint      sa, sb, q, r;
    hi = m_hi;
    lo = m_lo;
    case (op)
      4'd1: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
        hi = p[63:32];
        lo = p[31:0];
      end
      4'd2: begin
        p  = {32'd0, a} * {32'd0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      4'd3: if (b != 0) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        lo = 32'(q);
        hi = 32'(r);
      end
      4'd4: if (b != 0) begin
        lo = a / b;
        hi = a % b;
      end
      default: ;
    endcase
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int clr_at, input int inj_at);
    logic [31:0] eh, el;
    exp_t        e;
    int          len, k;
    k = 0;
    while (busy && k < 60) begin tick(); k++; end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    model(op, a, b, eh, el);
    len = (op <= 4'd2) ? MC : DC;
    start = 1'b1; MDUop = op; D1 = a; D2 = b;
    if (op == 4'd1 || op == 4'd2 || op == 4'd3 || op == 4'd4) begin
      if (clr_at > 0 && clr_at <= len) begin
        e.hi = m_hi; e.lo = m_lo; e.len = clr_at;
      end else begin
        m_hi = eh; m_lo = el;
        e.hi = m_hi; e.lo = m_lo; e.len = len;
      end
      exp_q.push_back(e);
    end else if (op == 4'd5) m_hi = a;
    else if (op == 4'd6) m_lo = a;
    tick();
    start = 1'b0; MDUop = 4'd0;
    k = 1;
    while (busy && k < 60) begin
      clear = (k == clr_at);
      if (k == inj_at) begin start = 1'b1; MDUop = 4'd6; D1 = 32'h55; end
      tick();
      clear = 1'b0; start = 1'b0; MDUop = 4'd0;
      k++;
    end
    if (busy) chk("busy_timeout", 32'(busy), 32'd0);
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    int          clr, inj;
    reset_n = 1'b1; start = 1'b0; clear = 1'b0; MDUop = 4'd0;
    D1 = '0; D2 = '0; rd_chk = 1'b0; m_hi = '0; m_lo = '0;
    #1 reset_n = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_HI", HI, 32'd0);
    chk("reset_LO", LO, 32'd0);
    tick(); tick();
    reset_n = 1'b1;

    do_op(4'd1, 32'hFFFF_FFFE, 32'd3, 0, 0); rd(4'd7); rd(4'd8);
    do_op(4'd2, 32'hFFFF_FFFE, 32'd3, 0, 0); rd(4'd7); rd(4'd8);
    do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 0, 0); rd(4'd7); rd(4'd8);
    do_op(4'd4, 32'd7, 32'd2, 0, 0);         rd(4'd7); rd(4'd8);
    do_op(4'd5, 32'h11, 32'd0, 0, 0);
    do_op(4'd4, 32'd9, 32'd0, 0, 0);         rd(4'd7);
    do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0); rd(4'd7); rd(4'd8);
    do_op(4'd1, 32'h1234, 32'h5678, 3, 0);   rd(4'd7); rd(4'd8);
    do_op(4'd4, 32'd100, 32'd7, DC, 0);      rd(4'd7); rd(4'd8);

    start = 1'b1; MDUop = 4'd6; D1 = 32'd5; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0; MDUop = 4'd0;
    rd(4'd8);

    do_op(4'd3, 32'd1000, 32'd7, 0, 2); rd(4'd8); rd(4'd0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 6));
      a  = $urandom();
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      clr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DC) : 0;
      inj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      do_op(op, a, b, clr, inj);
      rd(4'd7); rd(4'd8);
    end

    start = 1'b1; MDUop = 4'd1; D1 = 32'd3; D2 = 32'd4;
    tick();
    start = 1'b0; MDUop = 4'd0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_HI", HI, 32'd0);
    chk("async_LO", LO, 32'd0);
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    repeat (8) tick();
    chk("post_reset_busy", 32'(busy), 32'd0);
    rd(4'd7); rd(4'd8);

    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    do_op(4'd1, 32'd7, 32'd6, 0, 0); rd(4'd7); rd(4'd8);

    tick();
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
